// File: rtl/int_fp_mul.sv
// Dual-mode 16-bit multiplier: IEEE binary16 (mode=1) or signed int16 (mode=0).
// Latency 1 cycle, one op per cycle, no backpressure (no handshake, never stalls).
module int_fp_mul (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [15:0] input1,
    input  logic [15:0] input2,
    output logic [15:0] result,
    output logic        error
);

    // Integer path: out of range when the upper 17 bits are not a sign extension of bit 15
    logic signed [31:0] w_int_prod;
    logic               w_int_ovf;

    assign w_int_prod = $signed(input1) * $signed(input2);
    assign w_int_ovf  = (w_int_prod[31:15] != {17{w_int_prod[15]}});

    // FP16 field decode
    logic        w_sign;
    logic [4:0]  w_ea, w_eb;
    logic [9:0]  w_fa, w_fb;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

    assign w_sign   = input1[15] ^ input2[15];
    assign w_ea     = input1[14:10];
    assign w_eb     = input2[14:10];
    assign w_fa     = input1[9:0];
    assign w_fb     = input2[9:0];
    assign w_a_nan  = (w_ea == 5'd31) && (w_fa != 10'd0);
    assign w_b_nan  = (w_eb == 5'd31) && (w_fb != 10'd0);
    assign w_a_inf  = (w_ea == 5'd31) && (w_fa == 10'd0);
    assign w_b_inf  = (w_eb == 5'd31) && (w_fb == 10'd0);
    assign w_a_zero = (w_ea == 5'd0);
    assign w_b_zero = (w_eb == 5'd0);

    // Significand product, normalisation and round-to-nearest-even
    logic [10:0]       w_ma, w_mb;
    logic [21:0]       w_mprod;
    logic              w_norm;
    logic [10:0]       w_sig;
    logic              w_guard, w_sticky, w_rnd;
    logic [11:0]       w_sig_r;
    logic              w_carry;
    logic [9:0]        w_frac;
    logic signed [7:0] w_exp;

    assign w_ma     = {1'b1, w_fa};
    assign w_mb     = {1'b1, w_fb};
    assign w_mprod  = w_ma * w_mb;
    assign w_norm   = w_mprod[21];
    assign w_sig    = w_norm ? w_mprod[21:11] : w_mprod[20:10];
    assign w_guard  = w_norm ? w_mprod[10] : w_mprod[9];
    assign w_sticky = w_norm ? (|w_mprod[9:0]) : (|w_mprod[8:0]);
    assign w_rnd    = w_guard & (w_sticky | w_sig[0]);
    assign w_sig_r  = {1'b0, w_sig} + {11'd0, w_rnd};
    assign w_carry  = w_sig_r[11];
    assign w_frac   = w_carry ? w_sig_r[10:1] : w_sig_r[9:0];
    assign w_exp    = 8'(w_ea) + 8'(w_eb) - 8'd15 + 8'(w_norm) + 8'(w_carry);

    logic [15:0] w_fp_res;
    logic        w_fp_err;

    always_comb begin
        w_fp_res = 16'h0000;
        w_fp_err = 1'b0;
        if (w_a_nan || w_b_nan) begin
            w_fp_res = 16'h7E00;
            w_fp_err = 1'b1;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_fp_res = 16'h7E00;
            w_fp_err = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_fp_res = {w_sign, 15'h7C00};
        end else if (w_a_zero || w_b_zero) begin
            w_fp_res = {w_sign, 15'h0000};
        end else if (w_exp >= 8'sd31) begin
            w_fp_res = {w_sign, 15'h7C00};
            w_fp_err = 1'b1;
        end else if (w_exp <= 8'sd0) begin
            w_fp_res = {w_sign, 15'h0000};
        end else begin
            w_fp_res = {w_sign, w_exp[4:0], w_frac};
        end
    end

    logic [15:0] r_result;
    logic        r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= 16'h0000;
            r_error  <= 1'b0;
        end else if (mode) begin
            r_result <= w_fp_res;
            r_error  <= w_fp_err;
        end else begin
            r_result <= w_int_prod[15:0];
            r_error  <= w_int_ovf;
        end
    end

    assign result = r_result;
    assign error  = r_error;

endmodule

// File: tb/tb_int_fp_mul.sv
// Scoreboard bench for int_fp_mul: directed vectors plus randomized ops against a real-arithmetic model.
module tb_int_fp_mul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] input1 = 16'h0000;
    logic [15:0] input2 = 16'h0000;
    logic [15:0] result;
    logic        error;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    int_fp_mul dut (
        .clk    (clk),
        .rst    (rst),
        .mode   (mode),
        .input1 (input1),
        .input2 (input2),
        .result (result),
        .error  (error)
    );

    typedef struct packed {
        logic        m;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        e;
    } item_t;

    item_t sb[$];

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Magnitude of a normal binary16 value
    function automatic real fp_mag(input logic [15:0] x);
        return real'(1024 + int'(x[9:0])) * pow2(int'(x[14:10]) - 25);
    endfunction

    function automatic item_t model(input logic m, input logic [15:0] a, input logic [15:0] b);
        item_t  it;
        longint p;
        logic   s;
        bit     a_nan, b_nan, a_inf, b_inf, a_z, b_z;
        real    v, mm, fl, fr;
        int     e, fli, be;
        it.m = m; it.a = a; it.b = b; it.r = 16'h0; it.e = 1'b0;
        if (!m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            it.r = p[15:0];
            it.e = (p < -32768) || (p > 32767);
            return it;
        end
        s     = a[15] ^ b[15];
        a_nan = (a[14:10] == 5'd31) && (a[9:0] != 0);
        b_nan = (b[14:10] == 5'd31) && (b[9:0] != 0);
        a_inf = (a[14:10] == 5'd31) && (a[9:0] == 0);
        b_inf = (b[14:10] == 5'd31) && (b[9:0] == 0);
        a_z   = (a[14:10] == 5'd0);
        b_z   = (b[14:10] == 5'd0);
        if (a_nan || b_nan || (a_inf && b_z) || (b_inf && a_z)) begin
            it.r = 16'h7E00; it.e = 1'b1;
        end else if (a_inf || b_inf) begin
            it.r = {s, 15'h7C00};
        end else if (a_z || b_z) begin
            it.r = {s, 15'h0000};
        end else begin
            v = fp_mag(a) * fp_mag(b);
            e = 0;
            while (v >= 2.0) begin v = v / 2.0; e++; end
            while (v < 1.0)  begin v = v * 2.0; e--; end
            mm  = v * 1024.0;
            fl  = $floor(mm);
            fr  = mm - fl;
            fli = int'(fl);
            if (fr > 0.5 || (fr == 0.5 && (fli % 2) == 1)) fli++;
            if (fli >= 2048) begin fli = 1024; e++; end
            be = e + 15;
            if (be >= 31) begin
                it.r = {s, 15'h7C00}; it.e = 1'b1;
            end else if (be <= 0) begin
                it.r = {s, 15'h0000};
            end else begin
                it.r = {s, 5'(be), 10'(fli - 1024)};
            end
        end
        return it;
    endfunction

    task automatic drive(input logic r, input item_t it);
        @(negedge clk);
        rst    = r;
        mode   = it.m;
        input1 = it.a;
        input2 = it.b;
        sb.push_back(it);
    endtask

    // Monitor: one output per edge once stimulus has been issued
    always @(posedge clk) begin : mon
        item_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            tests++;
            if (result !== x.r || error !== x.e) begin
                fails++;
                $display("FAIL op m=%0b a=%h b=%h: got result=%h error=%b, expected result=%h error=%b",
                         x.m, x.a, x.b, result, error, x.r, x.e);
            end
        end
    end

    function automatic logic [15:0] rnd_op();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 9))
            0: x[14:10] = 5'd0;
            1: x[14:10] = 5'd31;
            2: x[9:0]   = 10'd0;
            default: ;
        endcase
        return x;
    endfunction

    item_t dir[$];
    item_t b2b[$];

    initial begin
        item_t it;
        dir.push_back('{1'b1, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0});
        dir.push_back('{1'b1, 16'h4000, 16'hC200, 16'hC600, 1'b0});
        dir.push_back('{1'b1, 16'h3E00, 16'h3E00, 16'h4080, 1'b0});
        dir.push_back('{1'b1, 16'h3C01, 16'h3C01, 16'h3C02, 1'b0});
        dir.push_back('{1'b1, 16'h8000, 16'h3C00, 16'h8000, 1'b0});
        dir.push_back('{1'b1, 16'h7C00, 16'hC000, 16'hFC00, 1'b0});
        dir.push_back('{1'b1, 16'h7BFF, 16'h4000, 16'h7C00, 1'b1});
        dir.push_back('{1'b1, 16'h7E00, 16'h3C00, 16'h7E00, 1'b1});
        dir.push_back('{1'b1, 16'h7C00, 16'h0000, 16'h7E00, 1'b1});
        dir.push_back('{1'b1, 16'h0400, 16'h0400, 16'h0000, 1'b0});
        dir.push_back('{1'b0, 16'h0003, 16'hFFFE, 16'hFFFA, 1'b0});
        dir.push_back('{1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1});
        dir.push_back('{1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1});
        dir.push_back('{1'b0, 16'h00B5, 16'h00B4, 16'h7F44, 1'b0});

        b2b.push_back('{1'b1, 16'h3C00, 16'h3C00, 16'h3C00, 1'b0});
        b2b.push_back('{1'b0, 16'h0003, 16'hFFFE, 16'hFFFA, 1'b0});
        b2b.push_back('{1'b1, 16'h4000, 16'hC200, 16'hC600, 1'b0});
        b2b.push_back('{1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1});
        b2b.push_back('{1'b1, 16'h3E00, 16'h3E00, 16'h4080, 1'b0});
        b2b.push_back('{1'b0, 16'h8000, 16'hFFFF, 16'h8000, 1'b1});
        b2b.push_back('{1'b1, 16'h7BFF, 16'h4000, 16'h7C00, 1'b1});
        b2b.push_back('{1'b0, 16'h00B5, 16'h00B4, 16'h7F44, 1'b0});
        b2b.push_back('{1'b1, 16'h7C00, 16'h0000, 16'h7E00, 1'b1});
        b2b.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0});

        // Reset held for two edges with arbitrary operands
        for (int i = 0; i < 2; i++)
            drive(1'b1, '{1'($urandom), 16'($urandom), 16'($urandom), 16'h0000, 1'b0});

        foreach (dir[i]) drive(1'b0, dir[i]);
        foreach (b2b[i]) drive(1'b0, b2b[i]);

        // Mid-stream reset discards the coinciding operation
        drive(1'b1, '{1'b1, 16'h3C00, 16'h4000, 16'h0000, 1'b0});
        drive(1'b0, '{1'b1, 16'h3C00, 16'h4000, 16'h4000, 1'b0});

        for (int i = 0; i < 3000; i++) begin
            logic m;
            m  = 1'($urandom);
            it = model(m, rnd_op(), rnd_op());
            drive(1'b0, it);
        end

        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected outputs never observed, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
